// File: rtl/construtor_caminho.sv
// construtor_caminho
// Walks the predecessor memory backwards from the destination node until it
// reaches the source node. Each visited node is written into the path buffer,
// with index 0 holding the destination.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   construir_caminho_in  level request; dropping it aborts the build
//   endereco_fonte_in     source node, sampled at start
//   endereco_destino_in   destination node, sampled at start
//   anterior_rd_out       one-cycle read strobe to the predecessor memory
//   anterior_addr_out     node whose predecessor is requested
//   anterior_data_in      predecessor returned by the memory
//   anterior_valid_in     anterior_data_in valid this cycle
//   caminho_wr_out        one-cycle write strobe to the path buffer
//   caminho_idx_out       write index (0 = destination)
//   caminho_data_out      node being written
//   tamanho_caminho_out   number of entries written
//   caminho_pronto_out    build finished (success or error)
//   erro_out              build failed
//
// Optional feature macro: CONSTRUTOR_CAMINHO_SENTINELA_EN
//   When defined, an all-ones predecessor means "no predecessor" and ends
//   the build in error without writing it.

module construtor_caminho #(
  parameter  int ADDR_WIDTH = 10,
  parameter  int MAX_PATH   = 256,
  localparam int CNT_WIDTH  = $clog2(MAX_PATH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  construir_caminho_in,
  input  logic [ADDR_WIDTH-1:0] endereco_fonte_in,
  input  logic [ADDR_WIDTH-1:0] endereco_destino_in,
  output logic                  anterior_rd_out,
  output logic [ADDR_WIDTH-1:0] anterior_addr_out,
  input  logic [ADDR_WIDTH-1:0] anterior_data_in,
  input  logic                  anterior_valid_in,
  output logic                  caminho_wr_out,
  output logic [CNT_WIDTH-1:0]  caminho_idx_out,
  output logic [ADDR_WIDTH-1:0] caminho_data_out,
  output logic [CNT_WIDTH-1:0]  tamanho_caminho_out,
  output logic                  caminho_pronto_out,
  output logic                  erro_out
);

  typedef enum logic [2:0] {
    IDLE,
    ESCREVER,
    LER,
    ESPERAR,
    PRONTO,
    ERRO
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] atual, atual_next;
  logic [ADDR_WIDTH-1:0] fonte, fonte_next;
  logic [CNT_WIDTH-1:0]  contador, contador_next;
  logic [CNT_WIDTH-1:0]  contador_inc;

  logic                  wr_next, rd_next, pronto_next, erro_next;
  logic [CNT_WIDTH-1:0]  idx_next;
  logic [ADDR_WIDTH-1:0] data_next, addr_next;

  assign contador_inc        = contador + CNT_WIDTH'(1);
  assign tamanho_caminho_out = contador;

  // Every output is registered together with the state, so the value
  // computed here for the next state is what the outputs show while
  // the FSM sits in that state (e.g. the write strobe is high exactly
  // during ESCREVER).
  always_comb begin
    state_next    = state;
    atual_next    = atual;
    fonte_next    = fonte;
    contador_next = contador;
    wr_next       = 1'b0;
    rd_next       = 1'b0;
    idx_next      = caminho_idx_out;
    data_next     = caminho_data_out;
    addr_next     = anterior_addr_out;
    pronto_next   = caminho_pronto_out;
    erro_next     = erro_out;

    case (state)
      IDLE: begin
        pronto_next = 1'b0;
        if (construir_caminho_in) begin
          fonte_next    = endereco_fonte_in;
          atual_next    = endereco_destino_in;
          contador_next = '0;
          erro_next     = 1'b0;
          wr_next       = 1'b1;
          idx_next      = '0;
          data_next     = endereco_destino_in;
          state_next    = ESCREVER;
        end
      end

      // The write is already on the bus; it counts even if the request
      // is withdrawn in this same cycle.
      ESCREVER: begin
        contador_next = contador_inc;
        if (!construir_caminho_in) begin
          state_next = IDLE;
        end else if (atual == fonte) begin
          pronto_next = 1'b1;
          erro_next   = 1'b0;
          state_next  = PRONTO;
        end else if (contador_inc == CNT_WIDTH'(MAX_PATH)) begin
          pronto_next = 1'b1;
          erro_next   = 1'b1;
          state_next  = ERRO;
        end else begin
          rd_next    = 1'b1;
          addr_next  = atual;
          state_next = LER;
        end
      end

      LER: begin
        if (!construir_caminho_in) state_next = IDLE;
        else                       state_next = ESPERAR;
      end

      // The memory may take any number of cycles to answer.
      ESPERAR: begin
        if (!construir_caminho_in) begin
          state_next = IDLE;
        end else if (anterior_valid_in) begin
`ifdef CONSTRUTOR_CAMINHO_SENTINELA_EN
          if (anterior_data_in == {ADDR_WIDTH{1'b1}}) begin
            pronto_next = 1'b1;
            erro_next   = 1'b1;
            state_next  = ERRO;
          end else begin
            atual_next = anterior_data_in;
            wr_next    = 1'b1;
            idx_next   = contador;
            data_next  = anterior_data_in;
            state_next = ESCREVER;
          end
`else
          atual_next = anterior_data_in;
          wr_next    = 1'b1;
          idx_next   = contador;
          data_next  = anterior_data_in;
          state_next = ESCREVER;
`endif
        end
      end

      // erro_out is left untouched on exit so that a failed build stays
      // visible until the next start.
      PRONTO, ERRO: begin
        if (!construir_caminho_in) begin
          pronto_next = 1'b0;
          state_next  = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      atual              <= '0;
      fonte              <= '0;
      contador           <= '0;
      caminho_wr_out     <= 1'b0;
      caminho_idx_out    <= '0;
      caminho_data_out   <= '0;
      anterior_rd_out    <= 1'b0;
      anterior_addr_out  <= '0;
      caminho_pronto_out <= 1'b0;
      erro_out           <= 1'b0;
    end else begin
      state              <= state_next;
      atual              <= atual_next;
      fonte              <= fonte_next;
      contador           <= contador_next;
      caminho_wr_out     <= wr_next;
      caminho_idx_out    <= idx_next;
      caminho_data_out   <= data_next;
      anterior_rd_out    <= rd_next;
      anterior_addr_out  <= addr_next;
      caminho_pronto_out <= pronto_next;
      erro_out           <= erro_next;
    end
  end

endmodule

// File: tb/tb_construtor_caminho.sv
// Bench for construtor_caminho: a default instance (MAX_PATH=256) and a
// small instance (MAX_PATH=4) share the stimulus. A one-cycle predecessor
// memory answers whichever instance is selected by sel_small.

module tb_construtor_caminho;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       construir;
  logic [9:0] fonte, destino;
  logic       sel_small;
  logic       mem_en;
  logic       mem_valid;
  logic [9:0] mem_data;
  logic       extra_valid;
  logic [9:0] extra_data;
  logic       valid_in;
  logic [9:0] data_in;
  logic [9:0] pred [0:1023];

  logic       wr_a, rd_a, pronto_a, erro_a;
  logic [8:0] idx_a, tam_a;
  logic [9:0] data_a, addr_a;

  logic       wr_b, rd_b, pronto_b, erro_b;
  logic [2:0] idx_b, tam_b;
  logic [9:0] data_b, addr_b;

  logic       wr_sel, rd_sel, pronto_sel, erro_sel;
  logic [8:0] idx_sel, tam_sel;
  logic [9:0] data_sel, addr_sel;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [8:0] wr_idx_q [$];
  logic [9:0] wr_data_q [$];
  int         rd_count;

  always #5 clk = ~clk;

  assign valid_in   = mem_valid | extra_valid;
  assign data_in    = extra_valid ? extra_data : mem_data;
  assign wr_sel     = sel_small ? wr_b : wr_a;
  assign rd_sel     = sel_small ? rd_b : rd_a;
  assign pronto_sel = sel_small ? pronto_b : pronto_a;
  assign erro_sel   = sel_small ? erro_b : erro_a;
  assign idx_sel    = sel_small ? {6'd0, idx_b} : idx_a;
  assign tam_sel    = sel_small ? {6'd0, tam_b} : tam_a;
  assign data_sel   = sel_small ? data_b : data_a;
  assign addr_sel   = sel_small ? addr_b : addr_a;

  construtor_caminho dut_a (
    .clk(clk), .rst_n(rst_n), .construir_caminho_in(construir),
    .endereco_fonte_in(fonte), .endereco_destino_in(destino),
    .anterior_rd_out(rd_a), .anterior_addr_out(addr_a),
    .anterior_data_in(data_in), .anterior_valid_in(valid_in),
    .caminho_wr_out(wr_a), .caminho_idx_out(idx_a), .caminho_data_out(data_a),
    .tamanho_caminho_out(tam_a), .caminho_pronto_out(pronto_a), .erro_out(erro_a)
  );

  construtor_caminho #(.ADDR_WIDTH(10), .MAX_PATH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .construir_caminho_in(construir),
    .endereco_fonte_in(fonte), .endereco_destino_in(destino),
    .anterior_rd_out(rd_b), .anterior_addr_out(addr_b),
    .anterior_data_in(data_in), .anterior_valid_in(valid_in),
    .caminho_wr_out(wr_b), .caminho_idx_out(idx_b), .caminho_data_out(data_b),
    .tamanho_caminho_out(tam_b), .caminho_pronto_out(pronto_b), .erro_out(erro_b)
  );

  // Predecessor memory with one cycle of latency: a read strobe seen at
  // a rising edge returns valid data during the following cycle.
  always @(posedge clk) begin
    mem_valid <= mem_en & rd_sel;
    mem_data  <= pred[addr_sel];
  end

  // Record every path write and every read strobe of the selected
  // instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_sel) begin
      wr_idx_q.push_back(idx_sel);
      wr_data_q.push_back(data_sel);
    end
    if (rd_sel) rd_count++;
  end

  task automatic clear_log();
    wr_idx_q.delete();
    wr_data_q.delete();
    rd_count = 0;
  endtask

  // Raise the request and count rising edges (the sampling edge is the
  // first) until the done flag is seen, bounded by max_cycles.
  task automatic start_and_wait(input int max_cycles, output int cycles);
    cycles = 0;
    @(negedge clk);
    construir = 1'b1;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!pronto_sel && cycles < max_cycles);
  endtask

  task automatic finish_build();
    @(negedge clk);
    construir = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({wr_a, idx_a, data_a, rd_a, addr_a, tam_a, pronto_a, erro_a} !== 42'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_a: outputs %h, expected 0",
               {wr_a, idx_a, data_a, rd_a, addr_a, tam_a, pronto_a, erro_a});
    end
    vectors++;
    if ({wr_b, idx_b, data_b, rd_b, addr_b, tam_b, pronto_b, erro_b} !== 30'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_b: outputs %h, expected 0",
               {wr_b, idx_b, data_b, rd_b, addr_b, tam_b, pronto_b, erro_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_chain();
    logic [9:0] exp_d [4] = '{10'd7, 10'd4, 10'd2, 10'd0};
    int cycles;
    pred[7] = 10'd4; pred[4] = 10'd2; pred[2] = 10'd0;
    fonte = 10'd0; destino = 10'd7;
    clear_log();
    start_and_wait(100, cycles);
    vectors++;
    if (cycles !== 11) begin
      miscompares++;
      $display("[TB] FAIL chain_latency: got %0d cycles, expected 11", cycles);
    end
    vectors++;
    if (wr_idx_q.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL chain_writes: got %0d writes, expected 4", wr_idx_q.size());
    end
    for (int i = 0; i < 4 && i < wr_idx_q.size(); i++) begin
      vectors++;
      if (wr_idx_q[i] !== 9'(i) || wr_data_q[i] !== exp_d[i]) begin
        miscompares++;
        $display("[TB] FAIL chain_entry%0d: got (%0d,%0d), expected (%0d,%0d)",
                 i, wr_idx_q[i], wr_data_q[i], i, exp_d[i]);
      end
    end
    vectors++;
    if (tam_sel !== 9'd4 || erro_sel !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL chain_result: tamanho %0d erro %0b, expected 4 and 0",
               tam_sel, erro_sel);
    end
    finish_build();
    vectors++;
    if (pronto_sel !== 1'b0 || tam_sel !== 9'd4) begin
      miscompares++;
      $display("[TB] FAIL chain_idle: pronto %0b tamanho %0d, expected 0 and 4",
               pronto_sel, tam_sel);
    end
  endtask

  task automatic test_same_node();
    int cycles;
    fonte = 10'd5; destino = 10'd5;
    clear_log();
    start_and_wait(100, cycles);
    vectors++;
    if (cycles !== 2 || rd_count !== 0) begin
      miscompares++;
      $display("[TB] FAIL same_node: got %0d cycles %0d reads, expected 2 and 0",
               cycles, rd_count);
    end
    vectors++;
    if (wr_idx_q.size() !== 1 || tam_sel !== 9'd1) begin
      miscompares++;
      $display("[TB] FAIL same_node_writes: got %0d writes tamanho %0d, expected 1 and 1",
               wr_idx_q.size(), tam_sel);
    end else begin
      vectors++;
      if (wr_idx_q[0] !== 9'd0 || wr_data_q[0] !== 10'd5) begin
        miscompares++;
        $display("[TB] FAIL same_node_entry: got (%0d,%0d), expected (0,5)",
                 wr_idx_q[0], wr_data_q[0]);
      end
    end
    finish_build();
  endtask

  task automatic test_max_path();
    int cycles;
    sel_small = 1'b1;
    pred[3] = 10'd3;
    fonte = 10'd0; destino = 10'd3;
    clear_log();
    start_and_wait(100, cycles);
    vectors++;
    if (cycles !== 11 || erro_sel !== 1'b1 || tam_sel !== 9'd4) begin
      miscompares++;
      $display("[TB] FAIL max_path: got %0d cycles erro %0b tamanho %0d, expected 11 1 4",
               cycles, erro_sel, tam_sel);
    end
    vectors++;
    if (wr_idx_q.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL max_path_writes: got %0d writes, expected 4", wr_idx_q.size());
    end
    for (int i = 0; i < 4 && i < wr_idx_q.size(); i++) begin
      vectors++;
      if (wr_idx_q[i] !== 9'(i) || wr_data_q[i] !== 10'd3) begin
        miscompares++;
        $display("[TB] FAIL max_path_entry%0d: got (%0d,%0d), expected (%0d,3)",
                 i, wr_idx_q[i], wr_data_q[i], i);
      end
    end
    finish_build();
    vectors++;
    if (erro_sel !== 1'b1 || pronto_sel !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL max_path_hold: erro %0b pronto %0b, expected 1 and 0",
               erro_sel, pronto_sel);
    end
    fonte = 10'd5; destino = 10'd5;
    clear_log();
    start_and_wait(100, cycles);
    vectors++;
    if (cycles !== 2 || erro_sel !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL max_path_restart: got %0d cycles erro %0b, expected 2 and 0",
               cycles, erro_sel);
    end
    finish_build();
    sel_small = 1'b0;
  endtask

  task automatic test_sentinel();
    int cycles;
    pred[9] = 10'h3FF;
    fonte = 10'h3FF; destino = 10'd9;
    clear_log();
    start_and_wait(100, cycles);
`ifdef CONSTRUTOR_CAMINHO_SENTINELA_EN
    vectors++;
    if (cycles !== 4 || erro_sel !== 1'b1 || tam_sel !== 9'd1 || wr_idx_q.size() !== 1) begin
      miscompares++;
      $display("[TB] FAIL sentinel_on: cycles %0d erro %0b tamanho %0d writes %0d, expected 4 1 1 1",
               cycles, erro_sel, tam_sel, wr_idx_q.size());
    end
`else
    vectors++;
    if (cycles !== 5 || erro_sel !== 1'b0 || tam_sel !== 9'd2 || wr_idx_q.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL sentinel_off: cycles %0d erro %0b tamanho %0d writes %0d, expected 5 0 2 2",
               cycles, erro_sel, tam_sel, wr_idx_q.size());
    end else begin
      vectors++;
      if (wr_idx_q[1] !== 9'd1 || wr_data_q[1] !== 10'h3FF) begin
        miscompares++;
        $display("[TB] FAIL sentinel_off_entry: got (%0d,%0h), expected (1,3ff)",
                 wr_idx_q[1], wr_data_q[1]);
      end
    end
`endif
    finish_build();
  endtask

  task automatic test_abort();
    int n = 0;
    int cycles;
    pred[7] = 10'd4; pred[4] = 10'd2; pred[2] = 10'd0;
    fonte = 10'd0; destino = 10'd7;
    mem_en = 1'b0;
    clear_log();
    @(negedge clk);
    construir = 1'b1;
    while (!rd_sel && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    construir = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    extra_valid = 1'b1;
    extra_data  = 10'd4;
    @(negedge clk);
    extra_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (wr_idx_q.size() !== 1 || rd_count !== 1) begin
      miscompares++;
      $display("[TB] FAIL abort_strobes: got %0d writes %0d reads, expected 1 and 1",
               wr_idx_q.size(), rd_count);
    end
    vectors++;
    if (pronto_sel !== 1'b0 || tam_sel !== 9'd1) begin
      miscompares++;
      $display("[TB] FAIL abort_idle: pronto %0b tamanho %0d, expected 0 and 1",
               pronto_sel, tam_sel);
    end
    mem_en = 1'b1;
    clear_log();
    start_and_wait(100, cycles);
    vectors++;
    if (cycles !== 11 || wr_data_q.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL abort_restart: got %0d cycles %0d writes, expected 11 and 4",
               cycles, wr_data_q.size());
    end
    finish_build();
  endtask

  task automatic test_reset_midway();
    logic [9:0] exp_d [4] = '{10'd7, 10'd4, 10'd2, 10'd0};
    int n = 0;
    int cycles;
    fonte = 10'd0; destino = 10'd7;
    clear_log();
    @(negedge clk);
    construir = 1'b1;
    while (!rd_sel && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({wr_a, idx_a, data_a, rd_a, addr_a, tam_a, pronto_a, erro_a} !== 42'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_midway: outputs %h, expected 0",
               {wr_a, idx_a, data_a, rd_a, addr_a, tam_a, pronto_a, erro_a});
    end
    @(negedge clk);
    construir = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    start_and_wait(100, cycles);
    vectors++;
    if (cycles !== 11 || tam_sel !== 9'd4) begin
      miscompares++;
      $display("[TB] FAIL reset_restart: got %0d cycles tamanho %0d, expected 11 and 4",
               cycles, tam_sel);
    end
    for (int i = 0; i < 4 && i < wr_data_q.size(); i++) begin
      vectors++;
      if (wr_data_q[i] !== exp_d[i]) begin
        miscompares++;
        $display("[TB] FAIL reset_restart_entry%0d: got %0d, expected %0d",
                 i, wr_data_q[i], exp_d[i]);
      end
    end
    finish_build();
  endtask

  // Scenario sequence; everything starts from reset with an all-zero
  // predecessor memory.
  initial begin
    rst_n       = 1'b0;
    construir   = 1'b0;
    fonte       = '0;
    destino     = '0;
    sel_small   = 1'b0;
    mem_en      = 1'b1;
    extra_valid = 1'b0;
    extra_data  = '0;
    rd_count    = 0;
    for (int i = 0; i < 1024; i++) pred[i] = '0;

    test_reset();
    test_chain();
    test_same_node();
    test_max_path();
    test_sentinel();
    test_abort();
    test_reset_midway();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
